// File: rtl/out_port_uart_tx.sv
// Captures register-file writes to the output register and sends them as 8N1 UART frames.
// Define OUT_PORT_UART_TX_PARITY_EN to insert an even-parity bit after the payload.
module out_port_uart_tx #(
   parameter int BUS_WIDTH    = 8,
   parameter int ADDR_WIDTH   = 3,
   parameter int OUT_ADDR     = 7,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [BUS_WIDTH-1:0]  wr_data,
   output logic                  tx,
   output logic                  ready_out,
   output logic                  busy,
   output logic                  overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

`ifdef OUT_PORT_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [BUS_WIDTH-1:0] shift_q, shift_d;
   logic [BUS_WIDTH-1:0] hold_q, hold_d;
   logic                 hold_valid_q, hold_valid_d;
   logic                 tx_q, tx_d;
   logic                 ready_q;
   logic                 busy_q;
   logic                 overrun_q, overrun_d;
`ifdef OUT_PORT_UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   logic wrap;
   logic cap;
   logic load;

   always_comb begin
      wrap = (baud_q == CW'(CLKS_PER_BIT - 1));
      cap  = we && (wr_addr == ADDR_WIDTH'(OUT_ADDR));
      // The shifter takes the held byte from IDLE or at the very end of STOP
      load = hold_valid_q &&
             ((state_q == IDLE) || ((state_q == STOP) && wrap));
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      if ((state_q == IDLE) || wrap) begin
         baud_d = '0;
      end else begin
         baud_d = baud_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (load) begin
               state_d = START;
               shift_d = hold_q;
               bit_d   = '0;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (wrap) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (wrap) begin
               if (bit_q == BW'(BUS_WIDTH - 1)) begin
`ifdef OUT_PORT_UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = parity_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
                  tx_d    = shift_d[0];
               end
            end
         end
`ifdef OUT_PORT_UART_TX_PARITY_EN
         PARITY: begin
            if (wrap) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (wrap) begin
               if (load) begin
                  state_d = START;
                  shift_d = hold_q;
                  bit_d   = '0;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q && !load;
      overrun_d    = overrun_q;
      if (cap) begin
         if (!hold_valid_q || load) begin
            hold_d       = wr_data;
            hold_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
`ifdef OUT_PORT_UART_TX_PARITY_EN
      parity_d = load ? ^hold_q : parity_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         baud_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         tx_q         <= 1'b1;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef OUT_PORT_UART_TX_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         tx_q         <= tx_d;
         ready_q      <= !hold_valid_d;
         busy_q       <= (state_d != IDLE);
         overrun_q    <= overrun_d;
`ifdef OUT_PORT_UART_TX_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign tx        = tx_q;
   assign ready_out = ready_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Randomised bench for out_port_uart_tx: per-cycle line model plus a frame decoder.
// Build with OUT_PORT_UART_TX_PARITY_EN to exercise the parity variant.
module tb_out_port_uart_tx;

   localparam int BW  = 8;
   localparam int AW  = 3;
   localparam int CPB = 4;
`ifdef OUT_PORT_UART_TX_PARITY_EN
   localparam int NB = BW + 3;
`else
   localparam int NB = BW + 2;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          we = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [BW-1:0] wr_data = '0;
   logic          tx, ready_out, busy, overrun;

   out_port_uart_tx #(
      .BUS_WIDTH(BW), .ADDR_WIDTH(AW),
      .OUT_ADDR(7), .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk), .rst(rst), .we(we),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .tx(tx), .ready_out(ready_out),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   // Reference: queue of line levels still to be shown, one per cycle
   logic          m_q[$];
   logic [BW-1:0] m_hold = '0;
   logic          m_full = 1'b0;
   logic          m_ovr = 1'b0;
   logic          m_tx = 1'b1;
   logic          m_busy = 1'b0;
   logic [BW-1:0] exp_b[$];
   int            rst_cnt = 0;
   bit            chk_en = 1'b0;

   task automatic push_frame(input logic [BW-1:0] d);
      for (int i = 0; i < CPB; i++) m_q.push_back(1'b0);
      for (int b = 0; b < BW; b++)
         for (int i = 0; i < CPB; i++) m_q.push_back(d[b]);
`ifdef OUT_PORT_UART_TX_PARITY_EN
      for (int i = 0; i < CPB; i++) m_q.push_back(^d);
`endif
      for (int i = 0; i < CPB; i++) m_q.push_back(1'b1);
   endtask

   always @(posedge clk) begin
      bit drain, cap;
      if (rst) begin
         m_q.delete();
         m_full = 1'b0;
         m_ovr  = 1'b0;
         m_tx   = 1'b1;
         m_busy = 1'b0;
         rst_cnt++;
      end else begin
         drain = m_full && (m_q.size() == 0);
         cap   = we && (wr_addr == 3'd7);
         if (drain) begin
            push_frame(m_hold);
            exp_b.push_back(m_hold);
         end
         if (cap) begin
            if (!m_full || drain) begin
               m_hold = wr_data;
               m_full = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (drain) begin
            m_full = 1'b0;
         end
         if (m_q.size() > 0) begin
            m_tx   = m_q.pop_front();
            m_busy = 1'b1;
         end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("tx", tx, m_tx);
         check("busy", busy, m_busy);
         check("ready_out", ready_out, !m_full);
         check("overrun", overrun, m_ovr);
      end
   end

   // Frame decoder: samples mid-bit and compares with bytes the model started
   logic [15:0]   lv;
   logic [BW-1:0] rx;
   int            rc;
   bit            abort;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && !rst && tx === 1'b0) begin
            rc    = rst_cnt;
            abort = 1'b0;
            lv    = '0;
            for (int k = 1; k <= (NB - 1) * CPB + CPB / 2; k++) begin
               @(negedge clk);
               if (rst_cnt != rc) begin
                  abort = 1'b1;
                  break;
               end
               if (k >= CPB / 2 && ((k - CPB / 2) % CPB) == 0)
                  lv[(k - CPB / 2) / CPB] = tx;
            end
            if (abort) begin
               if (exp_b.size() > 0) void'(exp_b.pop_front());
            end else begin
               rx = lv[BW:1];
               check("rx_stop", lv[NB-1], 1'b1);
`ifdef OUT_PORT_UART_TX_PARITY_EN
               check("rx_parity", lv[BW+1], ^rx);
`endif
               if (exp_b.size() > 0)
                  check("rx_byte", rx, exp_b.pop_front());
               else
                  check("rx_unexpected", 1'b1, 1'b0);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
      @(negedge clk);
      we      = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_tx", tx, 1'b1);
      check("rst_ready", ready_out, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_ovr", overrun, 1'b0);
      idle(100);

      wr(3'd7, 8'hA5);
      idle(60);
      wr(3'd6, 8'h3C);
      idle(60);

      wr(3'd7, 8'h01);
      wr(3'd7, 8'h80);
      idle(110);

      wr(3'd7, 8'h11);
      wr(3'd7, 8'h22);
      wr(3'd7, 8'h33);
      idle(110);
      check("ovr_sticky", overrun, 1'b1);

      wr(3'd7, 8'hFF);
      wr(3'd7, 8'h55);
      idle(12);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_tx", tx, 1'b1);
      check("midrst_ready", ready_out, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_ovr", overrun, 1'b0);
      idle(80);

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         we      = ($urandom_range(0, 11) == 0);
         wr_addr = $urandom_range(0, 1) ? 3'd7
                                        : AW'($urandom_range(0, 6));
         wr_data = BW'($urandom);
      end
      @(negedge clk);
      we = 1'b0;
      idle(150);
      check("all_frames_seen", exp_b.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
